// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave: FSM state encoding, SPI mode
// constants ({polarity, phase}) and the byte width. Also provides a helper
// that tells whether a given mode samples MOSI on the rising spi_clk edge.
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int SPI_BYTE_W = 8;

   typedef enum logic [1:0] {
      SPI_IDLE  = 2'd0,
      SPI_LOAD  = 2'd1,
      SPI_SHIFT = 2'd2
   } spi_state_t;

   // Mode constants, encoded as {polarity, phase}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling
   // edge; the shift edge is always the opposite transition.
   function automatic logic sample_on_rise(input logic [1:0] mode);
      return (mode == MODE0) || (mode == MODE3);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Synchronises one asynchronous input into the clk domain through a
// SYNC_STAGES-deep flop chain and detects edges by comparing the synchronised
// level with a one-cycle-delayed copy.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth (2..3)
//   RESET_VALUE  value the chain and delayed copy take during reset
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   din      in   asynchronous input
//   level    out  synchronised level
//   rise     out  one-cycle pulse on a synchronised 0->1 transition
//   fall     out  one-cycle pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // NOTE: non-blocking assignments so each stage captures its neighbour's
   // pre-edge value; blocking here would collapse the chain into one flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RESET_VALUE}};
         prev_q <= RESET_VALUE;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI slave for all four polarity/phase modes. spi_clk, cs and mosi are
// synchronised into the clk domain; MSB-first bytes are assembled onto
// rx_data/rx_valid and, when the transmit path is compiled in, tx_data is
// serialised MSB-first onto miso. Multi-byte frames run within one cs low.
//
// Build option:
//   SPI_SLAVE_MISO_EN  defined   -> TX shifter, tx_load and miso drive present
//                      undefined -> receive-only: miso=1, tx_load=0
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   polarity   in   spi_clk idle level (static while cs low)
//   phase      in   0: sample on leading edge, 1: sample on trailing edge
//   spi_clk    in   SPI clock from master (asynchronous)
//   cs         in   chip select, active low
//   mosi       in   serial data from master
//   miso       out  serial data to master
//   rx_data    out  last complete received byte
//   rx_valid   out  one-cycle pulse when rx_data updates
//   tx_data    in   byte to transmit, captured at each load point
//   tx_load    out  one-cycle pulse when tx_data has been captured
//   busy       out  high while a transfer is in progress (SHIFT state)
//   bit_count  out  bits received so far in the current byte
// -----------------------------------------------------------------------------
module spi_slave
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  polarity,
   input  logic                  phase,
   input  logic                  spi_clk,
   input  logic                  cs,
   input  logic                  mosi,
   output logic                  miso,
   output logic [SPI_BYTE_W-1:0] rx_data,
   output logic                  rx_valid,
   input  logic [SPI_BYTE_W-1:0] tx_data,
   output logic                  tx_load,
   output logic                  busy,
   output logic [2:0]            bit_count
);

   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic mosi_level, mosi_rise, mosi_fall;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (spi_clk),
      .level   (sclk_level),
      .rise    (sclk_rise),
      .fall    (sclk_fall)
   );

   // cs resets high so leaving reset never looks like a chip-select fall
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (cs),
      .level   (cs_level),
      .rise    (cs_rise),
      .fall    (cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (mosi),
      .level   (mosi_level),
      .rise    (mosi_rise),
      .fall    (mosi_fall)
   );

   // Map the mode onto physical spi_clk transitions
   logic sample_edge, shift_edge;

   // NOTE: every output gets a default first, so no path leaves a value
   // unassigned and no latch is inferred.
   always_comb begin
      sample_edge = 1'b0;
      shift_edge  = 1'b0;
      if (sample_on_rise({polarity, phase})) begin
         sample_edge = sclk_rise;
         shift_edge  = sclk_fall;
      end else begin
         sample_edge = sclk_fall;
         shift_edge  = sclk_rise;
      end
   end

   spi_state_t            state;
   logic [SPI_BYTE_W-1:0] rx_shift;

`ifdef SPI_SLAVE_MISO_EN
   logic [SPI_BYTE_W-1:0] tx_shift;
   // Set when a fresh byte sits in tx_shift and the next shift edge must
   // present its MSB rather than advance the shifter.
   logic                  first_shift;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= SPI_IDLE;
         rx_shift  <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         bit_count <= '0;
         busy      <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
         tx_shift    <= '0;
         first_shift <= 1'b0;
         miso        <= 1'b1;
         tx_load     <= 1'b0;
`endif
      end else begin
         rx_valid <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
         tx_load  <= 1'b0;
`endif
         // A cs rise ends the frame from any state and wins over a
         // coincident sample edge, discarding any partial byte.
         if (cs_rise) begin
            state     <= SPI_IDLE;
            bit_count <= '0;
            rx_shift  <= '0;
            busy      <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
            miso        <= 1'b1;
            first_shift <= 1'b0;
`endif
         end else begin
            case (state)
               SPI_IDLE: begin
                  bit_count <= '0;
                  busy      <= 1'b0;
                  if (cs_fall) state <= SPI_LOAD;
               end

               SPI_LOAD: begin
                  state <= SPI_SHIFT;
                  busy  <= 1'b1;
`ifdef SPI_SLAVE_MISO_EN
                  tx_shift    <= tx_data;
                  tx_load     <= 1'b1;
                  // phase 0: master samples before any shift edge, so the
                  // MSB must be on miso already.
                  first_shift <= phase;
                  if (!phase) miso <= tx_data[SPI_BYTE_W-1];
`endif
               end

               SPI_SHIFT: begin
                  if (sample_edge) begin
                     rx_shift  <= {rx_shift[SPI_BYTE_W-2:0], mosi_level};
                     bit_count <= bit_count + 3'd1;
                     if (bit_count == 3'd7) begin
                        rx_data  <= {rx_shift[SPI_BYTE_W-2:0], mosi_level};
                        rx_valid <= 1'b1;
`ifdef SPI_SLAVE_MISO_EN
                        tx_shift    <= tx_data;
                        tx_load     <= 1'b1;
                        first_shift <= 1'b1;
`endif
                     end
                  end
`ifdef SPI_SLAVE_MISO_EN
                  if (shift_edge) begin
                     if (first_shift) begin
                        miso        <= tx_shift[SPI_BYTE_W-1];
                        first_shift <= 1'b0;
                     end else begin
                        tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
                        miso     <= tx_shift[SPI_BYTE_W-2];
                     end
                  end
`endif
               end

               default: begin
                  state <= SPI_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Synchroniser outputs this design has no use for
   logic unused_sigs;

`ifdef SPI_SLAVE_MISO_EN
   assign unused_sigs = ^{sclk_level, cs_level, mosi_rise, mosi_fall};
`else
   // Receive-only build: transmit side is constant
   assign miso        = 1'b1;
   assign tx_load     = 1'b0;
   assign unused_sigs = ^{sclk_level, cs_level, mosi_rise, mosi_fall, tx_data};
`endif

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Self-checking bench for spi_slave. A master model drives SPI frames in all
// four modes; expected received bytes go into a scoreboard queue that an
// independent monitor drains whenever rx_valid pulses. The master also
// collects miso at its own sample edges and compares against the bytes the
// producer handed over on each tx_load.
// -----------------------------------------------------------------------------
module tb_spi_slave;

   localparam int HALF    = 4;   // clk cycles per spi_clk phase (spi_clk = clk/8)
   localparam int LAT     = 3;   // SYNC_STAGES + 1
   localparam int CS_LAT  = 4;   // SYNC_STAGES + 2

`ifdef SPI_SLAVE_MISO_EN
   localparam bit MISO_ON = 1'b1;
`else
   localparam bit MISO_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n, polarity, phase, spi_clk, cs, mosi;
   logic       miso, rx_valid, tx_load, busy;
   logic [7:0] rx_data, tx_data;
   logic [2:0] bit_count;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } rx_exp_t;

   rx_exp_t    rx_q[$];
   logic [7:0] last_rx;
   logic [7:0] mosi_bytes[4];
   logic [7:0] tx_seq[5];
   int         load_idx, load_cnt;
   int         shift_cyc   = -100;
   int         cs_fall_cyc = -100;
   bit         timing_on;

   spi_slave #(.SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .polarity  (polarity),
      .phase     (phase),
      .spi_clk   (spi_clk),
      .cs        (cs),
      .mosi      (mosi),
      .miso      (miso),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_load   (tx_load),
      .busy      (busy),
      .bit_count (bit_count)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Scoreboard monitor: received bytes and miso change timing
   initial begin : monitor
      rx_exp_t e;
      logic    prev_miso;
      prev_miso = 1'b1;
      forever begin
         @(negedge clk);
         if (rx_valid === 1'b1) begin
            if (rx_q.size() == 0) begin
               check("rx_valid_unexpected", rx_valid, 0);
            end else begin
               e = rx_q.pop_front();
               check("rx_data", rx_data, e.data);
               check("rx_latency", cyc - e.cyc, LAT);
            end
         end
         // While selected, miso may only move LAT cycles after a shift edge
         // or CS_LAT cycles after the cs fall.
         if (timing_on && cs === 1'b0 && miso !== prev_miso && (cyc - cs_fall_cyc) != CS_LAT)
            check("miso_change_delay", cyc - shift_cyc, LAT);
         prev_miso = miso;
      end
   end

   // Producer: after each tx_load, present the next byte for the next load point
   initial forever begin
      @(negedge clk);
      if (tx_load === 1'b1) begin
         load_cnt++;
         if (load_idx < 4) load_idx++;
         @(posedge clk);
         #1;
         tx_data = tx_seq[load_idx];
      end
   end

   // One cs-low frame of nbytes. stop_bit >= 0 aborts (cs rise) or, with
   // do_reset, asserts reset_n at the start of that bit.
   task automatic run_frame(input logic pol, input logic ph, input int nbytes,
                            input int stop_bit, input bit do_reset);
      logic [7:0] got[4];
      logic [7:0] sh;
      int         done;
      sh   = '0;
      done = nbytes;
      polarity = pol;
      phase    = ph;
      spi_clk  = pol;
      cs       = 1'b1;
      load_idx = 0;
      load_cnt = 0;
      tx_data  = tx_seq[0];
      repeat (6) @(negedge clk);
      cs = 1'b0;
      cs_fall_cyc = cyc;
      repeat (8) @(negedge clk);
      check("busy_active", busy, 1);
      for (int b = 0; b < nbytes * 8; b++) begin
         if (b == stop_bit) begin
            done = b / 8;
            if (do_reset) begin
               timing_on = 1'b0;
               reset_n   = 1'b0;
               #1;
               check("rst_miso", miso, 1);
               check("rst_rx_data", rx_data, 0);
               check("rst_rx_valid", rx_valid, 0);
               check("rst_tx_load", tx_load, 0);
               check("rst_busy", busy, 0);
               check("rst_bit_count", bit_count, 0);
               cs      = 1'b1;
               spi_clk = pol;
               mosi    = 1'b0;
               repeat (4) @(negedge clk);
               reset_n = 1'b1;
               repeat (4) @(negedge clk);
               last_rx   = 8'h00;
               timing_on = 1'b1;
               return;
            end
            break;
         end
         mosi = mosi_bytes[b / 8][7 - (b % 8)];
         if (ph) begin
            spi_clk   = ~spi_clk;
            shift_cyc = cyc;
         end
         repeat (HALF) @(negedge clk);
         sh      = {sh[6:0], miso};
         spi_clk = ~spi_clk;
         if (b % 8 == 7) begin
            rx_q.push_back('{data: mosi_bytes[b / 8], cyc: cyc});
            last_rx     = mosi_bytes[b / 8];
            got[b / 8]  = sh;
         end
         repeat (HALF) @(negedge clk);
         check("bit_count", bit_count, (b + 1) % 8);
         if (!ph) begin
            spi_clk   = ~spi_clk;
            shift_cyc = cyc;
         end
      end
      repeat (HALF) @(negedge clk);
      cs = 1'b1;
      repeat (8) @(negedge clk);
      check("idle_bit_count", bit_count, 0);
      check("idle_busy", busy, 0);
      check("idle_miso", miso, 1);
      check("rx_data_held", rx_data, last_rx);
      for (int i = 0; i < done; i++)
         check("miso_byte", got[i], MISO_ON ? tx_seq[i] : 8'hFF);
      check("tx_load_count", load_cnt, MISO_ON ? done + 1 : 0);
   endtask

   task automatic fill_tx();
      for (int i = 0; i < 5; i++) tx_seq[i] = 8'($urandom_range(0, 255));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n   = 1'b0;
      cs        = 1'b1;
      spi_clk   = 1'b0;
      mosi      = 1'b0;
      polarity  = 1'b0;
      phase     = 1'b0;
      tx_data   = 8'h00;
      timing_on = 1'b0;
      last_rx   = 8'h00;
      load_idx  = 0;
      load_cnt  = 0;
      repeat (3) @(negedge clk);
      check("reset_miso", miso, 1);
      check("reset_rx_data", rx_data, 0);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_tx_load", tx_load, 0);
      check("reset_busy", busy, 0);
      check("reset_bit_count", bit_count, 0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      timing_on = 1'b1;

      // Mode 0: receive 0xA5, transmit 0x3C
      fill_tx();
      mosi_bytes[0] = 8'hA5;
      tx_seq[0]     = 8'h3C;
      run_frame(1'b0, 1'b0, 1, -1, 1'b0);

      // Modes 1..3: receive 0x5A
      for (int m = 1; m < 4; m++) begin
         fill_tx();
         mosi_bytes[0] = 8'h5A;
         run_frame(m[1], m[0], 1, -1, 1'b0);
      end

      // Two-byte frame, second TX byte supplied after the first tx_load
      fill_tx();
      mosi_bytes[0] = 8'h12;
      mosi_bytes[1] = 8'h34;
      tx_seq[0]     = 8'h3C;
      tx_seq[1]     = 8'h56;
      run_frame(1'b0, 1'b0, 2, -1, 1'b0);

      // Abort after 5 bits of 0xFF, then a clean 0x81
      fill_tx();
      mosi_bytes[0] = 8'hFF;
      run_frame(1'b0, 1'b0, 1, 5, 1'b0);
      fill_tx();
      mosi_bytes[0] = 8'h81;
      run_frame(1'b0, 1'b0, 1, -1, 1'b0);

      // Reset at bit 3, then 0xC3
      fill_tx();
      mosi_bytes[0] = 8'h96;
      run_frame(1'b0, 1'b0, 1, 3, 1'b1);
      fill_tx();
      mosi_bytes[0] = 8'hC3;
      run_frame(1'b0, 1'b0, 1, -1, 1'b0);

      // Random frames: random mode, length and data
      for (int f = 0; f < 10; f++) begin
         int mode;
         int nb;
         fill_tx();
         for (int i = 0; i < 4; i++) mosi_bytes[i] = 8'($urandom_range(0, 255));
         mode = $urandom_range(0, 3);
         nb   = $urandom_range(1, 4);
         run_frame(mode[1], mode[0], nb, -1, 1'b0);
      end

      repeat (10) @(negedge clk);
      check("rx_queue_drained", rx_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
